// File: rtl/moving_sprite_if.sv
// moving_sprite_if
// Pixel-stream and motion-control bundle for the moving_sprite block.
//   i_hcount / i_vcount    : current pixel column / row from the video timing source
//   i_new_frame / i_enable : once-per-frame update strobe and motion enable
//   i_dx / i_dy            : per-frame speed on each axis (unsigned)
//   o_red/o_green/o_blue   : registered pixel colour
//   o_in_sprite            : registered hit flag aligned with the colour
//   o_x / o_y              : current top-left sprite position
//   o_bounce               : one-cycle pulse on any edge bounce
//   o_bounce_count         : wrapping count of bounces since reset
// The "master" side is the video timing / control source, "slave" is the sprite.
interface moving_sprite_if;
    logic [10:0] i_hcount;
    logic [9:0]  i_vcount;
    logic        i_new_frame;
    logic        i_enable;
    logic [3:0]  i_dx;
    logic [3:0]  i_dy;
    logic [7:0]  o_red;
    logic [7:0]  o_green;
    logic [7:0]  o_blue;
    logic        o_in_sprite;
    logic [10:0] o_x;
    logic [9:0]  o_y;
    logic        o_bounce;
    logic [7:0]  o_bounce_count;

    modport master (
        output i_hcount, i_vcount, i_new_frame, i_enable, i_dx, i_dy,
        input  o_red, o_green, o_blue, o_in_sprite, o_x, o_y, o_bounce, o_bounce_count
    );

    modport slave (
        input  i_hcount, i_vcount, i_new_frame, i_enable, i_dx, i_dy,
        output o_red, o_green, o_blue, o_in_sprite, o_x, o_y, o_bounce, o_bounce_count
    );
endinterface

// File: rtl/moving_sprite.sv
// moving_sprite
// Rectangle sprite that bounces around the active video area. The position is
// updated once per frame (on i_new_frame with i_enable) and the pixel stream is
// rendered through a two-stage registered hit pipeline.
//   i_clk   : pixel clock, all state changes on its rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : moving_sprite_if.slave (pixel coordinates, motion control, outputs)
module moving_sprite #(
    parameter int          WIDTH    = 128,
    parameter int          HEIGHT   = 128,
    parameter logic [23:0] COLOR    = 24'hFF_FF_FF,
    parameter int          H_ACTIVE = 1280,
    parameter int          V_ACTIVE = 720,
    parameter int          INIT_X   = 0,
    parameter int          INIT_Y   = 0,
    parameter int          MODE     = 0,
    parameter int          BORDER   = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    moving_sprite_if.slave bus
);
    // All edge arithmetic is carried out in 12 bits so x+WIDTH etc. never wrap.
    localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - WIDTH);
    localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - HEIGHT);
    localparam logic [11:0] W12    = 12'(WIDTH);
    localparam logic [11:0] H12    = 12'(HEIGHT);
    localparam logic [11:0] B12    = 12'(BORDER);
    localparam logic [11:0] HA12   = 12'(H_ACTIVE);
    localparam logic [11:0] VA12   = 12'(V_ACTIVE);

    logic [10:0] x_r;
    logic [9:0]  y_r;
    logic        dir_x_r;
    logic        dir_y_r;
    logic        bounce_r;
    logic [7:0]  bounce_count_r;

    logic        in_x_r;
    logic        in_y_r;
    logic        active_r;
    logic        edge_r;
    logic        in_sprite_r;
    logic [23:0] color_r;

    logic [11:0] x_ext_s, y_ext_s, dx_ext_s, dy_ext_s, x_sum_s, y_sum_s;
    logic [10:0] x_nxt_s;
    logic [9:0]  y_nxt_s;
    logic        dir_x_nxt_s, dir_y_nxt_s, bounce_x_s, bounce_y_s;
    logic [11:0] hc_s, vc_s, x_end_s, y_end_s;
    logic        edge_s, hit_s;

    assign x_ext_s  = {1'b0, x_r};
    assign y_ext_s  = {2'b00, y_r};
    assign dx_ext_s = {8'h00, bus.i_dx};
    assign dy_ext_s = {8'h00, bus.i_dy};
    assign x_sum_s  = x_ext_s + dx_ext_s;
    assign y_sum_s  = y_ext_s + dy_ext_s;

    // Next X position / direction; a zero speed freezes the axis even at an edge.
    always_comb begin
        x_nxt_s     = x_r;
        dir_x_nxt_s = dir_x_r;
        bounce_x_s  = 1'b0;
        if (bus.i_dx == 4'd0) begin
            x_nxt_s = x_r;
        end else if (dir_x_r == 1'b0) begin
            if (x_sum_s >= X_MAX) begin
                x_nxt_s     = X_MAX[10:0];
                dir_x_nxt_s = 1'b1;
                bounce_x_s  = 1'b1;
            end else begin
                x_nxt_s = 11'(x_sum_s);
            end
        end else begin
            if (x_ext_s <= dx_ext_s) begin
                x_nxt_s     = 11'd0;
                dir_x_nxt_s = 1'b0;
                bounce_x_s  = 1'b1;
            end else begin
                x_nxt_s = 11'(x_ext_s - dx_ext_s);
            end
        end
    end

    // Next Y position / direction, same rules as X.
    always_comb begin
        y_nxt_s     = y_r;
        dir_y_nxt_s = dir_y_r;
        bounce_y_s  = 1'b0;
        if (bus.i_dy == 4'd0) begin
            y_nxt_s = y_r;
        end else if (dir_y_r == 1'b0) begin
            if (y_sum_s >= Y_MAX) begin
                y_nxt_s     = Y_MAX[9:0];
                dir_y_nxt_s = 1'b1;
                bounce_y_s  = 1'b1;
            end else begin
                y_nxt_s = 10'(y_sum_s);
            end
        end else begin
            if (y_ext_s <= dy_ext_s) begin
                y_nxt_s     = 10'd0;
                dir_y_nxt_s = 1'b0;
                bounce_y_s  = 1'b1;
            end else begin
                y_nxt_s = 10'(y_ext_s - dy_ext_s);
            end
        end
    end

    // Motion state: commit position on enabled frame strobe; a corner bounce counts once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_r            <= 11'(INIT_X);
            y_r            <= 10'(INIT_Y);
            dir_x_r        <= 1'b0;
            dir_y_r        <= 1'b0;
            bounce_r       <= 1'b0;
            bounce_count_r <= 8'd0;
        end else if (bus.i_new_frame && bus.i_enable) begin
            x_r      <= x_nxt_s;
            y_r      <= y_nxt_s;
            dir_x_r  <= dir_x_nxt_s;
            dir_y_r  <= dir_y_nxt_s;
            bounce_r <= bounce_x_s | bounce_y_s;
            if (bounce_x_s | bounce_y_s) begin
                bounce_count_r <= bounce_count_r + 8'd1;
            end
        end else begin
            bounce_r <= 1'b0;
        end
    end

    assign hc_s    = {1'b0, bus.i_hcount};
    assign vc_s    = {2'b00, bus.i_vcount};
    assign x_end_s = x_ext_s + W12;
    assign y_end_s = y_ext_s + H12;
    // Outline band: within BORDER pixels of any sprite edge (BORDER <= WIDTH/HEIGHT).
    assign edge_s  = (hc_s < (x_ext_s + B12)) || (hc_s >= (x_end_s - B12)) ||
                     (vc_s < (y_ext_s + B12)) || (vc_s >= (y_end_s - B12));

    // Hit stage 1: compare the pixel against the current-cycle position.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_x_r   <= 1'b0;
            in_y_r   <= 1'b0;
            active_r <= 1'b0;
            edge_r   <= 1'b0;
        end else begin
            in_x_r   <= (hc_s >= x_ext_s) && (hc_s < x_end_s);
            in_y_r   <= (vc_s >= y_ext_s) && (vc_s < y_end_s);
            active_r <= (hc_s < HA12) && (vc_s < VA12);
            edge_r   <= edge_s;
        end
    end

    assign hit_s = in_x_r && in_y_r && active_r && ((MODE == 1) ? edge_r : 1'b1);

    // Hit stage 2: registered hit flag and colour.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_sprite_r <= 1'b0;
            color_r     <= 24'h00_00_00;
        end else begin
            in_sprite_r <= hit_s;
            color_r     <= hit_s ? COLOR : 24'h00_00_00;
        end
    end

    assign bus.o_red          = color_r[23:16];
    assign bus.o_green        = color_r[15:8];
    assign bus.o_blue         = color_r[7:0];
    assign bus.o_in_sprite    = in_sprite_r;
    assign bus.o_x            = x_r;
    assign bus.o_y            = y_r;
    assign bus.o_bounce       = bounce_r;
    assign bus.o_bounce_count = bounce_count_r;
endmodule

// File: doc/moving_sprite.md
MOVING_SPRITE -- requirements
Module: moving_sprite

Interface
REQ-001 Parameter WIDTH, default 128; sprite width in pixels, 1..H_ACTIVE.
REQ-002 Parameter HEIGHT, default 128; sprite height in pixels, 1..V_ACTIVE.
REQ-003 Parameter COLOR, default 24'hFF_FF_FF; sprite colour, {R[23:16],G[15:8],B[7:0]}.
REQ-004 Parameter H_ACTIVE, default 1280; active pixels per line.
REQ-005 Parameter V_ACTIVE, default 720; active lines per frame.
REQ-006 Parameter INIT_X, default 0; INIT_Y, default 0; position after reset.
REQ-007 Parameter MODE, default 0; 0 = solid fill, 1 = outline only.
REQ-008 Parameter BORDER, default 4; outline thickness in pixels when MODE=1, 1..min(WIDTH,HEIGHT)/2.
REQ-009 i_clk  in  1  pixel clock; all state updates on its rising edge.
REQ-010 i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-011 i_hcount  in  11  current pixel column.
REQ-012 i_vcount  in  10  current pixel row.
REQ-013 i_new_frame  in  1  single-cycle pulse, once per frame, during blanking.
REQ-014 i_enable  in  1  motion enable, sampled only with i_new_frame.
REQ-015 i_dx  in  4  horizontal speed, pixels/frame, unsigned.
REQ-016 i_dy  in  4  vertical speed, pixels/frame, unsigned.
REQ-017 o_red, o_green, o_blue  out  8 each  pixel colour, registered.
REQ-018 o_in_sprite  out  1  registered hit flag, aligned with colour outputs.
REQ-019 o_x  out  11; o_y  out  10  current top-left position.
REQ-020 o_bounce  out  1  single-cycle pulse when any edge bounce occurs.
REQ-021 o_bounce_count  out  8  bounces since reset, wraps 255->0.

Function
REQ-022 Position update occurs only in a cycle with i_new_frame=1 and i_enable=1; otherwise x, y, directions hold.
REQ-023 Direction registers dir_x, dir_y: 0 = increasing, 1 = decreasing.
REQ-024 X update, dir_x=0: if x+i_dx >= H_ACTIVE-WIDTH then x <= H_ACTIVE-WIDTH, dir_x <= 1, bounce; else x <= x+i_dx.
REQ-025 X update, dir_x=1: if x <= i_dx then x <= 0, dir_x <= 0, bounce; else x <= x-i_dx.
REQ-026 Y update identical to REQ-024/025 with y, i_dy, dir_y, V_ACTIVE, HEIGHT.
REQ-027 i_dx=0 (i_dy=0) leaves that axis unchanged with no bounce and no direction flip, even at an edge.
REQ-028 Edge arithmetic is 12 bits wide; no intermediate sum wraps.
REQ-029 o_bounce pulses one cycle after the updating edge; a simultaneous X and Y bounce (corner) gives one pulse and increments o_bounce_count by 1.
REQ-030 Hit stage 1 (registered): in_x = (i_hcount >= x) and (i_hcount < x+WIDTH); in_y likewise with i_vcount, y, HEIGHT; edge flags for MODE=1 = within BORDER of any sprite edge.
REQ-031 Stage 2 (registered): o_in_sprite = in_x and in_y, further ANDed with the edge flag when MODE=1; colour = COLOR if o_in_sprite, else 0.
REQ-032 Pixel latency is exactly 2 cycles from i_hcount/i_vcount to colour and o_in_sprite.
REQ-033 Stage 1 compares against the x/y register value of the same cycle; the new position applies from the cycle after the i_new_frame edge.
REQ-034 Pixels outside the active area (i_hcount >= H_ACTIVE or i_vcount >= V_ACTIVE) output 0 and o_in_sprite=0.

Reset
REQ-035 While i_rst_n=0: x=INIT_X, y=INIT_Y, dir_x=dir_y=0, both pipeline stages cleared, colour outputs 0, o_in_sprite=0, o_bounce=0, o_bounce_count=0.
REQ-036 Reset asserted mid-frame or mid-pipeline clears immediately without waiting for i_clk; the first valid output appears 2 cycles after the first post-release pixel.

Verification
REQ-037 INIT_X=100, INIT_Y=50, i_enable=1, i_dx=4, i_dy=2, one i_new_frame -> o_x=104, o_y=52, o_bounce=0.
REQ-038 x=1150, dir_x=0, i_dx=4, WIDTH=128, H_ACTIVE=1280, new frame -> o_x=1152, dir_x=1, o_bounce one pulse, o_bounce_count=1; next frame -> o_x=1148.
REQ-039 x=2, y=1, both directions decreasing, i_dx=i_dy=3, new frame -> o_x=0, o_y=0, one o_bounce pulse, count +1.
REQ-040 x=100, y=50, MODE=0: hcount/vcount=(100,50) -> COLOR and o_in_sprite=1 two cycles later; (228,50) -> 0; (99,50) -> 0.
REQ-041 MODE=1, BORDER=4, x=100, y=50: (103,60) -> COLOR; (104,60) -> 0; (150,177) -> COLOR.
REQ-042 i_rst_n low mid-frame after several bounces -> outputs 0 immediately, o_x=INIT_X, o_bounce_count=0; i_enable=0 with new frame -> position unchanged.
